// File: rtl/alu_seq_datapath.sv
// rtl/alu_seq_datapath.sv - multi-cycle ALU datapath with FSM, serial SHL and shift-add MUL
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_seq_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic [2:0]            opcode_value,
  input  logic                  store_a,
  input  logic                  store_b,
  input  logic                  start,
  output logic                  busy,
  output logic                  alu_done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic                  clear_sticky,
  output logic                  overflow_sticky
`endif
);
  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_PAR  = 3'd2;
  localparam logic [2:0] OP_COMP = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  state_t             r_state;
  logic [W-1:0]       r_buf_a;
  logic [W-1:0]       r_buf_b;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_result;
  logic [2:0]         r_op;
  logic [2*W-1:0]     r_mc;
  logic [2*W-1:0]     r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_sovf;
  logic               r_ovf;
  logic               r_done;

  logic [SHAMT_W-1:0] w_shamt;
  logic [W:0]         w_sum;
  logic [2*W-1:0]     w_acc_next;
  logic               w_fin;
  logic [W-1:0]       w_fin_res;
  logic               w_fin_ovf;

  assign w_shamt    = r_b[SHAMT_W-1:0];
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  // MUL consumes the multiplier LSB-first from r_b while r_mc walks left
  assign w_acc_next = r_b[0] ? (r_acc + r_mc) : r_acc;

  always_comb begin
    w_fin     = 1'b1;
    w_fin_res = '0;
    w_fin_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_fin_res = w_sum[W-1:0];
        w_fin_ovf = w_sum[W];
      end
      OP_SUB: begin
        w_fin_res = r_a - r_b;
        w_fin_ovf = (r_a < r_b);
      end
      OP_PAR:  w_fin_res = {{(W-1){1'b0}}, ^(r_a ^ r_b)};
      OP_COMP: begin
        if (r_a > r_b)      w_fin_res = W'(1);
        else if (r_a < r_b) w_fin_res = W'(2);
      end
      OP_AND:  w_fin_res = r_a & r_b;
      OP_OR:   w_fin_res = r_a | r_b;
      OP_SHL: begin
        if (w_shamt == '0) begin
          w_fin_res = r_a;
        end else begin
          w_fin     = (r_cnt == w_shamt - SHAMT_W'(1));
          w_fin_res = r_a << 1;
          w_fin_ovf = r_sovf | r_a[W-1];
        end
      end
      OP_MUL: begin
        w_fin     = (r_cnt == SHAMT_W'(W - 1));
        w_fin_res = w_acc_next[W-1:0];
        w_fin_ovf = |w_acc_next[2*W-1:W];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_buf_a  <= '0;
      r_buf_b  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_mc     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sovf   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (store_a) begin
            r_buf_a <= alu_data;
          end else if (store_b) begin
            r_buf_b <= alu_data;
          end else if (start) begin
            r_op    <= opcode_value;
            r_a     <= r_buf_a;
            r_b     <= r_buf_b;
            r_mc    <= {{W{1'b0}}, r_buf_a};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sovf  <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op == OP_SHL && w_shamt != '0) begin
            r_a    <= r_a << 1;
            r_sovf <= r_sovf | r_a[W-1];
            r_cnt  <= r_cnt + SHAMT_W'(1);
          end else if (r_op == OP_MUL) begin
            r_acc <= w_acc_next;
            r_mc  <= r_mc << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + SHAMT_W'(1);
          end
          if (w_fin) begin
            r_result <= w_fin_res;
            r_ovf    <= w_fin_ovf;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign alu_done = r_done;
  assign result   = r_result;
  assign overflow = r_ovf;

`ifdef ALU_STICKY_OVF_EN
  logic r_sticky;

  // a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset)                r_sticky <= 1'b0;
    else if (r_done && r_ovf) r_sticky <= 1'b1;
    else if (clear_sticky)    r_sticky <= 1'b0;
  end

  assign overflow_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_alu_seq_datapath.sv
// tb/tb_alu_seq_datapath.sv - scoreboard bench for alu_seq_datapath
module tb_alu_seq_datapath;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_data;
  logic [2:0] opcode_value;
  logic       store_a;
  logic       store_b;
  logic       start;
  logic       busy;
  logic       alu_done;
  logic [7:0] result;
  logic       overflow;
`ifdef ALU_STICKY_OVF_EN
  logic       clear_sticky;
  logic       overflow_sticky;
`endif

  alu_seq_datapath #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_data     (alu_data),
    .opcode_value (opcode_value),
    .store_a      (store_a),
    .store_b      (store_b),
    .start        (start),
    .busy         (busy),
    .alu_done     (alu_done),
    .result       (result),
    .overflow     (overflow)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clear_sticky    (clear_sticky),
    .overflow_sticky (overflow_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_done = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (alu_done === 1'b1) begin
      n_done <= n_done + 1;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("overflow", overflow, mon_e.ovf);
        check("latency", cyc, mon_e.when);
      end
    end
  end

  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (op)
      3'd0: model = {1'b0, a} + {1'b0, b};
      3'd1: model = {(a < b), 8'(a - b)};
      3'd2: model = {8'd0, ^(a ^ b)};
      3'd3: model = {1'b0, (a > b) ? 8'd1 : ((a < b) ? 8'd2 : 8'd0)};
      3'd4: model = {1'b0, a & b};
      3'd5: model = {1'b0, a | b};
      3'd6: begin p = {8'd0, a} << b[2:0]; model = {|p[15:8], p[7:0]}; end
      default: begin p = 16'(a) * 16'(b); model = {|p[15:8], p[7:0]}; end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd7) return 9;
    if (op == 3'd6) return (b[2:0] == 3'd0) ? 2 : int'(b[2:0]) + 1;
    return 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    alu_data = a; store_a = 1'b1; tick(); store_a = 1'b0;
    alu_data = b; store_b = 1'b1; tick(); store_b = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] op, input logic [7:0] er, input logic eo, input int lat);
    exp_t e;
    e.res = er; e.ovf = eo; e.when = cyc + lat;
    sb.push_back(e);
    opcode_value = op; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    check("drain", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic eo, input int lat);
    load(a, b);
    do_start(op, er, eo, lat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [8:0] m;
    reset = 1'b1; alu_data = '0; opcode_value = '0;
    store_a = 1'b0; store_b = 1'b0; start = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    clear_sticky = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", alu_done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    run_op(3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 2);
    run_op(3'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 2);
    run_op(3'd7, 8'h0F, 8'h03, 8'h2D, 1'b0, 9);
    run_op(3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 9);
    run_op(3'd6, 8'h81, 8'h03, 8'h08, 1'b1, 4);
    run_op(3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 2);
    run_op(3'd2, 8'h0F, 8'h01, 8'h01, 1'b0, 2);
    run_op(3'd3, 8'h10, 8'h20, 8'h02, 1'b0, 2);
    run_op(3'd3, 8'h20, 8'h10, 8'h01, 1'b0, 2);
    run_op(3'd3, 8'h5A, 8'h5A, 8'h00, 1'b0, 2);

    // back-to-back: relaunch in the first IDLE cycle using retained buffers
    do_start(3'd0, 8'hB4, 1'b0, 2);
    wait_idle();
    do_start(3'd5, 8'h5A, 1'b0, 2);
    wait_idle();

    // inputs ignored while MUL runs
    load(8'h33, 8'h02);
    d0 = n_done;
    do_start(3'd7, 8'h66, 1'b0, 9);
    tick();
    alu_data = 8'hAA; store_a = 1'b1; store_b = 1'b1; start = 1'b1; opcode_value = 3'd0;
    tick(); tick();
    check("busy_exec", busy, 1);
    tick();
    store_a = 1'b0; store_b = 1'b0; start = 1'b0;
    wait_idle();
    check("one_done", n_done - d0, 1);
    do_start(3'd0, 8'h35, 1'b0, 2);
    wait_idle();

    // store_a wins over start in IDLE
    d0 = n_done;
    alu_data = 8'h44; store_a = 1'b1; start = 1'b1; opcode_value = 3'd1;
    tick();
    store_a = 1'b0; start = 1'b0;
    check("no_launch_busy", busy, 0);
    repeat (4) tick();
    check("no_launch_done", n_done - d0, 0);
    do_start(3'd0, 8'h46, 1'b0, 2);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      m  = model(op, a, b);
      run_op(op, a, b, m[7:0], m[8], lat_of(op, b));
    end

`ifdef ALU_STICKY_OVF_EN
    run_op(3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 2);
    check("sticky_set", overflow_sticky, 1);
    run_op(3'd4, 8'h0F, 8'h3C, 8'h0C, 1'b0, 2);
    check("sticky_hold", overflow_sticky, 1);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    check("sticky_clear", overflow_sticky, 0);
`endif

    // reset during EXEC cycle 4 of MUL aborts without alu_done
    load(8'h0F, 8'h0F);
    do_start(3'd7, 8'hE1, 1'b0, 9);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", alu_done, 0);
    check("abort_result", result, 0);
    check("abort_ovf", overflow, 0);
    reset = 1'b0;
    sb.delete();
    d0 = n_done;
    repeat (12) tick();
    check("abort_no_done", n_done - d0, 0);
    do_start(3'd0, 8'h00, 1'b0, 2);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
